// File: rtl/wb_master_pkg.sv
// wb_master_pkg: FSM states and Wishbone cycle-type constants shared by the burst master
package wb_master_pkg;
  typedef enum logic [1:0] {IDLE, WAITDATA, BUS, FINISH} state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam int MAX_BEATS = 8;
endpackage

// File: rtl/wb_master_timeout.sv
// wb_master_timeout: counts cycles spent waiting for an ack and flags the last allowed one
module wb_master_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_expired
);
  logic [7:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= i_run ? r_cnt + 8'd1 : 8'd0;
  end
  assign o_expired = i_run && r_cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B4 incrementing-burst master for up to eight 32-bit beats
module wb_burst_master import wb_master_pkg::*; #(
  parameter int AW = 26,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [3:0]    cmd_sel,
  input  logic [3:0]    cmd_len,
  input  logic          wdat_valid,
  output logic          wdat_ready,
  input  logic [31:0]   wdat_data,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic          done,
  output logic          err,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic [2:0]    wb_cti_o,
  input  logic          wb_ack_i,
  input  logic [31:0]   wb_dat_i
);
  state_t r_state, w_next;
  logic r_we, r_rsp_valid, r_err;
  logic [AW-1:0] r_addr;
  logic [3:0] r_sel;
  logic [2:0] r_len, r_beat;
  logic [31:0] r_dat, r_rsp_data;
  logic w_ack, w_last, w_run, w_expired;
  assign w_ack = r_state == BUS && wb_ack_i;
  assign w_last = r_beat == r_len;
  assign w_run = r_state == BUS && !wb_ack_i;
  wb_master_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk(wb_clk_i),
    .i_rst_n(wb_rst_n_i),
    .i_run(w_run),
    .o_expired(w_expired)
  );
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (cmd_valid) w_next = cmd_we ? WAITDATA : BUS;
      WAITDATA: if (wdat_valid) w_next = BUS;
      BUS: w_next = w_ack ? (w_last ? FINISH : (r_we ? WAITDATA : BUS)) : (w_expired ? IDLE : BUS);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_we <= 1'b0;
      r_addr <= '0;
      r_sel <= '0;
      r_len <= '0;
      r_beat <= '0;
      r_dat <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data <= '0;
      r_err <= 1'b0;
    end else begin
      r_rsp_valid <= w_ack && !r_we;
      r_err <= w_expired;
      if (w_ack && !r_we) r_rsp_data <= wb_dat_i;
      if (r_state == IDLE && cmd_valid) begin
        r_we <= cmd_we;
        r_addr <= cmd_addr;
        r_sel <= cmd_sel;
        r_len <= cmd_len >= 4'(MAX_BEATS) ? 3'(MAX_BEATS - 1) : cmd_len[2:0];
        r_beat <= '0;
      end
      if (r_state == WAITDATA && wdat_valid) r_dat <= wdat_data;
      if (w_ack && !w_last) begin
        r_addr <= r_addr + AW'(4);
        r_beat <= r_beat + 3'd1;
      end
    end
  end
  assign cmd_ready = r_state == IDLE;
  assign wdat_ready = r_state == WAITDATA;
  assign wb_cyc_o = r_state == WAITDATA || r_state == BUS;
  assign wb_stb_o = r_state == BUS;
  assign wb_we_o = r_we;
  assign wb_addr_o = r_addr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = r_sel;
  assign wb_cti_o = r_len == 3'd0 ? CTI_CLASSIC : (w_last ? CTI_EOB : CTI_INCR);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data = r_rsp_data;
  assign done = r_state == FINISH;
  assign err = r_err;
endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter AW, default 26: Wishbone byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: max cycles waiting for wb_ack_i per beat, range 1..255.
REQ-003 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst_n_i  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-007 cmd_we  in  1  1=write burst, 0=read burst.
REQ-008 cmd_addr  in  AW  start byte address, 4-byte aligned.
REQ-009 cmd_sel  in  4  byte select, applied to every beat.
REQ-010 cmd_len  in  4  beat count minus one (0..7); values 8..15 are clamped to 7.
REQ-011 wdat_valid  in  1  write data available.
REQ-012 wdat_ready  out  1  write data consumed this cycle.
REQ-013 wdat_data  in  32  write beat data.
REQ-014 rsp_valid  out  1  one-cycle read-data strobe, no backpressure.
REQ-015 rsp_data  out  32  read beat data.
REQ-016 done  out  1  one-cycle pulse when the final beat is acked.
REQ-017 err  out  1  one-cycle pulse on timeout abort.
REQ-018 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone B4 cycle/strobe/write.
REQ-019 wb_addr_o  out  AW  beat byte address.
REQ-020 wb_dat_o  out  32  write data; wb_sel_o  out  4  byte select.
REQ-021 wb_cti_o  out  3  010 incrementing, 111 end-of-burst, 000 classic.
REQ-022 wb_ack_i  in  1  slave acknowledge; wb_dat_i  in  32  read data.

Function
REQ-023 FSM states IDLE, WAITDATA, BUS, FINISH; cmd_ready=1 only in IDLE.
REQ-024 IDLE: on accept, latch we/addr/sel/len and clear beat counter; go to BUS for a read, WAITDATA for a write; wb_cyc_o rises the cycle after accept.
REQ-025 WAITDATA: wb_cyc_o=1, wb_stb_o=0, wdat_ready=1; on wdat_valid, latch wdat_data into wb_dat_o and go to BUS next cycle.
REQ-026 BUS: wb_cyc_o=wb_stb_o=1; address, data, sel and cti SHALL be held stable until wb_ack_i.
REQ-027 cti: len=0 gives 000; otherwise 010 on every beat except the last, which gives 111.
REQ-028 On ack of a non-final beat: wb_addr_o+=4 (wraps modulo 2^AW); beat counter +1; write returns to WAITDATA, read stays in BUS with stb continuous.
REQ-029 Read ack: rsp_valid=1 and rsp_data=wb_dat_i registered, both visible the cycle after ack.
REQ-030 Final-beat ack: drop cyc/stb next cycle, enter FINISH; FINISH pulses done for one cycle, then returns to IDLE.
REQ-031 Timeout counter clears on every entry to BUS and counts while waiting for ack; at TIMEOUT, drop cyc/stb, pulse err, go to IDLE, no done, and discard remaining beats.
REQ-032 wb_ack_i while wb_stb_o=0 SHALL be ignored; wdat_valid outside WAITDATA SHALL be ignored.
REQ-033 wb_cyc_o SHALL stay asserted for the whole burst, including WAITDATA gaps.

Reset
REQ-034 wb_rst_n_i low at any clock edge, including mid-burst: FSM to IDLE; all Wishbone outputs, rsp_valid, done, err, wdat_ready and counters to 0; cmd_ready=1 in the first cycle after release.

Structure
REQ-035 Package wb_master_pkg SHALL hold the state enum, CTI constants (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111) and MAX_BEATS=8.
REQ-036 No sub-module SHALL be used except an optional wb_master_timeout counter.

Verification
REQ-037 Single read at 0x100, slave acks after 2 cycles with 0xDEADBEEF -> cti=000, one rsp_valid with 0xDEADBEEF, then done.
REQ-038 4-beat write at 0x200, data A0..A3, immediate acks -> addresses 0x200/204/208/20C, cti 010,010,010,111, cyc held throughout, done once.
REQ-039 4-beat write with wdat_valid absent for 3 cycles before beat 2 -> stb low and cyc high during the gap, beat-2 address 0x204 unchanged.
REQ-040 TIMEOUT=16 and no ack -> err pulses 16 cycles after stb rises; cyc drops; no done.
REQ-041 Read burst at 0x3FFFFFC with len=1 -> second address 0x0000000 (wrap).
REQ-042 Reset asserted during beat 3 of 8 -> outputs 0 next edge; a new command is accepted immediately after release.
